hist_sequencer: RTL
===================

HIST_SEQUENCER -- requirements
Module: hist_sequencer

Interface
REQ-001 Parameter NUM_BINS, default 4096, number of histogram bins read per run (power of two, ≥2).
REQ-002 Parameter DATA_WIDTH, default 32, bin count width.
REQ-003 Parameter FIFO_DEPTH, default 16, readout buffer entries (power of two).
REQ-004 Parameter CLEAR_CYCLES, default 4, cycles spent in CLEAR.
REQ-005 Parameter READ_TIMEOUT, default 1024, max idle cycles between bins in READ.
REQ-006 clk  in  1  sole clock; all logic rising-edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  one-cycle run request; honoured only in IDLE.
REQ-009 abort_i  in  1  abandon current run.
REQ-010 cfg_click_channel_i / cfg_start_channel_i  in  6 each  signed channel numbers.
REQ-011 cfg_shift_val_i  in  6  bin shift.
REQ-012 cfg_acq_cycles_i  in  32  acquisition length in clk cycles.
REQ-013 hist_config_en_o  out  1; hist_click_channel_o, hist_start_channel_o, hist_shift_val_o  out  6 each; hist_reset_o  out  1; hist_read_start_o  out  1: histogram control.
REQ-014 hist_data_i  in  DATA_WIDTH, hist_valid_i  in  1: histogram bin stream, no backpressure.
REQ-015 m_axis_tdata  out  DATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1: bin output stream.
REQ-016 busy_o  out  1; done_o  out  1 (pulse); error_o  out  2 sticky {timeout, overflow}.

Function
REQ-017 States: IDLE, CONFIG, CLEAR, ACQUIRE, READ, DRAIN, DONE; all outputs registered.
REQ-018 IDLE + start_i at cycle N: cfg_* captured, error_o cleared, CONFIG at N+1; hist_config_en_o high for exactly cycle N+1 with captured values driven on hist_*_o (held stable until next capture).
REQ-019 CONFIG -> CLEAR after 1 cycle; hist_reset_o high only on first CLEAR cycle; CLEAR lasts CLEAR_CYCLES cycles.
REQ-020 ACQUIRE lasts exactly cfg_acq_cycles_i cycles; value 0 treated as 1.
REQ-021 READ: hist_read_start_o high only on first READ cycle; each hist_valid_i beat written to FIFO and bin counter incremented; counter == NUM_BINS -> DRAIN.
REQ-022 hist_valid_i outside READ ignored.
REQ-023 READ: READ_TIMEOUT consecutive cycles without hist_valid_i -> error_o[1] set, FIFO flushed, IDLE.
REQ-024 hist_valid_i with FIFO full (same-cycle pop counts as free slot) -> beat dropped, error_o[0] set, bin counter still increments.
REQ-025 FIFO first-word-fall-through; m_axis_tvalid = FIFO non-empty; pop on tvalid && tready; tdata stable while tvalid && !tready.
REQ-026 m_axis_tlast high on output beat carrying bin index NUM_BINS-1 (output-side counter; with drops, on last buffered beat of the run).
REQ-027 DRAIN -> DONE when FIFO empty and no pending beat; DONE lasts 1 cycle with done_o high, then IDLE.
REQ-028 busy_o high in every state except IDLE.
REQ-029 abort_i in any non-IDLE state: next cycle IDLE, FIFO flushed, m_axis_tvalid low, no done_o, error_o unchanged; abort_i wins over start_i in same cycle.
REQ-030 start_i while not IDLE ignored.

Reset
REQ-031 rst: state IDLE, FIFO empty, counters 0, all outputs 0 including hist_*_o, error_o, m_axis_*; rst mid-run has same effect as from power-up and dominates abort_i/start_i.

Verification
REQ-032 NUM_BINS=8, acq=10, start at cycle 0 -> config_en cycle 1, hist_reset cycle 2, read_start cycle 16; 8 bins emitted with tready=1, tlast on 8th, done_o one cycle after last pop.
REQ-033 tready toggled 1/0 each cycle, FIFO_DEPTH=16, NUM_BINS=8 -> all 8 bins in order, tdata stable during stalls, error_o=0.
REQ-034 FIFO_DEPTH=4, NUM_BINS=8, tready=0 throughout READ -> error_o=2'b01, bins 5-8 dropped, 4 beats delivered after tready=1, tlast on 4th, done_o.
REQ-035 READ_TIMEOUT=16, only 3 bins supplied -> error_o=2'b10 at 16th idle cycle, busy_o low next cycle, no done_o.
REQ-036 abort_i during ACQUIRE and again during READ with 2 bins buffered -> IDLE next cycle, m_axis_tvalid low, no done_o; following start_i completes normally.
REQ-037 rst asserted in READ -> all outputs 0 next cycle; start_i with acq=0 afterwards -> one-cycle ACQUIRE.

Source files
------------

// File: rtl/hist_sequencer.sv
// hist_sequencer: run sequencer for an external histogrammer.
// Each run configures the histogrammer, clears it, lets it acquire for a
// programmed number of cycles, then streams NUM_BINS bin counts through a
// first-word-fall-through buffer onto an AXI-Stream style output.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start_i, abort_i            run request (IDLE only) / abandon run
//   cfg_*_i                     run configuration, captured on start
//   hist_*_o                    histogrammer control (config, clear, read)
//   hist_data_i, hist_valid_i   bin stream from the histogrammer
//   m_axis_*                    bin output stream
//   busy_o, done_o, error_o     status; error_o = {timeout, overflow}, sticky
//
// state     | meaning
// S_IDLE    | waiting for start_i
// S_CONFIG  | configuration strobe to the histogrammer
// S_CLEAR   | histogram clear, CLEAR_CYCLES long
// S_ACQUIRE | acquisition window, cfg_acq_cycles_i long (0 acts as 1)
// S_READ    | collecting bins into the buffer, watchdog running
// S_DRAIN   | all bins counted, emptying the buffer
// S_DONE    | one-cycle completion pulse
module hist_sequencer #(
    parameter int NUM_BINS     = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLEAR_CYCLES = 4,
    parameter int READ_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [5:0]            cfg_click_channel_i,
    input  logic [5:0]            cfg_start_channel_i,
    input  logic [5:0]            cfg_shift_val_i,
    input  logic [31:0]           cfg_acq_cycles_i,
    output logic                  hist_config_en_o,
    output logic [5:0]            hist_click_channel_o,
    output logic [5:0]            hist_start_channel_o,
    output logic [5:0]            hist_shift_val_o,
    output logic                  hist_reset_o,
    output logic                  hist_read_start_o,
    input  logic [DATA_WIDTH-1:0] hist_data_i,
    input  logic                  hist_valid_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            error_o
);

    localparam int BIN_W = $clog2(NUM_BINS) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BIN_W-1:0] LAST_BIN     = BIN_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      CLEAR_LOAD   = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_LOAD = 32'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_CLEAR, S_ACQUIRE, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             timer_q, timer_d;
    logic [31:0]             acq_q, acq_d;
    logic [BIN_W-1:0]        bin_cnt_q, bin_cnt_d;
    logic [BIN_W-1:0]        out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [5:0]              click_q, click_d, chan_q, chan_d, shift_q, shift_d;
    logic                    cfg_en_q, cfg_en_d, clr_q, clr_d, rd_start_q, rd_start_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [1:0]              error_q, error_d;
    logic                    tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    wr_en, flush, pop;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        acq_d      = acq_q;
        bin_cnt_d  = bin_cnt_q;
        out_cnt_d  = out_cnt_q;
        click_d    = click_q;
        chan_d     = chan_q;
        shift_d    = shift_q;
        error_d    = error_q;
        wr_en      = 1'b0;
        flush      = 1'b0;
        pop        = tvalid_q && m_axis_tready;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    click_d   = cfg_click_channel_i;
                    chan_d    = cfg_start_channel_i;
                    shift_d   = cfg_shift_val_i;
                    acq_d     = cfg_acq_cycles_i;
                    error_d   = 2'b00;
                    bin_cnt_d = '0;
                    out_cnt_d = '0;
                    state_d   = S_CONFIG;
                end
            end
            S_CONFIG: begin
                timer_d = CLEAR_LOAD;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (timer_q == '0) begin
                    timer_d = (acq_q == '0) ? '0 : acq_q - 32'd1;
                    state_d = S_ACQUIRE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_ACQUIRE: begin
                if (timer_q == '0) begin
                    timer_d = TIMEOUT_LOAD;
                    state_d = S_READ;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_READ: begin
                if (hist_valid_i) begin
                    timer_d   = TIMEOUT_LOAD;
                    bin_cnt_d = bin_cnt_q + 1'b1;
                    // a pop in the same cycle frees the slot being written
                    if (count_q != FULL_CNT || pop) begin
                        wr_en = 1'b1;
                    end else begin
                        error_d[0] = 1'b1;
                    end
                    if (bin_cnt_q == LAST_BIN) begin
                        state_d = S_DRAIN;
                    end
                end else if (timer_q == '0) begin
                    error_d[1] = 1'b1;
                    flush      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_DRAIN: begin
                if (count_q == '0 || (count_q == CNT_W'(1) && pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            flush   = 1'b1;
            wr_en   = 1'b0;
            error_d = error_q;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
            rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
            count_d   = count_q + CNT_W'(wr_en) - CNT_W'(pop);
            out_cnt_d = out_cnt_d + BIN_W'(pop);
        end

        // The next head entry is being written this very cycle when the
        // buffer is (effectively) empty, so bypass the memory in that case.
        if (wr_en && wr_ptr_q == rd_ptr_d) begin
            head_data = hist_data_i;
        end else begin
            head_data = fifo_mem[rd_ptr_d];
        end

        tvalid_d = (count_d != '0);
        tdata_d  = tvalid_d ? head_data : tdata_q;
        // With drops the index NUM_BINS-1 never appears; once no more
        // writes can arrive the single remaining entry is the last one.
        tlast_d  = tvalid_d && (out_cnt_d == LAST_BIN ||
                                (state_d == S_DRAIN && count_d == CNT_W'(1)));

        cfg_en_d   = (state_d == S_CONFIG);
        clr_d      = (state_q == S_CONFIG) && (state_d == S_CLEAR);
        rd_start_d = (state_q == S_ACQUIRE) && (state_d == S_READ);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            acq_q      <= '0;
            bin_cnt_q  <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            click_q    <= '0;
            chan_q     <= '0;
            shift_q    <= '0;
            cfg_en_q   <= 1'b0;
            clr_q      <= 1'b0;
            rd_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 2'b00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            acq_q      <= acq_d;
            bin_cnt_q  <= bin_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            click_q    <= click_d;
            chan_q     <= chan_d;
            shift_q    <= shift_d;
            cfg_en_q   <= cfg_en_d;
            clr_q      <= clr_d;
            rd_start_q <= rd_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= hist_data_i;
        end
    end

    assign hist_config_en_o     = cfg_en_q;
    assign hist_click_channel_o = click_q;
    assign hist_start_channel_o = chan_q;
    assign hist_shift_val_o     = shift_q;
    assign hist_reset_o         = clr_q;
    assign hist_read_start_o    = rd_start_q;
    assign m_axis_tdata         = tdata_q;
    assign m_axis_tvalid        = tvalid_q;
    assign m_axis_tlast         = tlast_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign error_o              = error_q;

endmodule
